// File: rtl/i2c_pkg.sv
// Shared I2C types and constants for the target responder and the master.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ_LOAD,
        READ,
        READ_ACK,
        IGNORE
    } i2cState_t;

    localparam logic [6:0] PCF8591_ADDR = 7'h48;
    localparam logic       I2C_ACK      = 1'b0;
    localparam logic       I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with SCL edge and START/STOP pulse detection.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] sclPipe;
    logic [SYNC_STAGES-1:0] sdaPipe;
    logic                   sclPrev;
    logic                   sdaPrev;

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclPipe <= '1;
            sdaPipe <= '1;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPipe <= {sclPipe[SYNC_STAGES-2:0], scl_in};
            sdaPipe <= {sdaPipe[SYNC_STAGES-2:0], sda_in};
            sclPrev <= scl_s;
            sdaPrev <= sda_s;
        end
    end

    assign scl_s    = sclPipe[SYNC_STAGES-1];
    assign sda_s    = sdaPipe[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~sclPrev;
    assign scl_fall = ~scl_s & sclPrev;
    assign start    = scl_s & sclPrev & sdaPrev & ~sda_s;
    assign stop     = scl_s & sclPrev & ~sdaPrev & sda_s;

endmodule

// File: rtl/i2c_target_pcf.sv
// PCF8591-style I2C target: address match, control/data writes, user-fed reads.
// Define I2C_TARGET_CLOCK_STRETCH_EN to stretch SCL while read data is not ready.
//
// state     | meaning
// IDLE      | bus idle, waiting for START
// ADDR      | shifting in address byte
// ADDR_ACK  | ACK clock for the address (or give up on mismatch)
// WRITE     | shifting in a write byte
// WRITE_ACK | ACK clock for a write byte
// READ_LOAD | fetching the next byte to send
// READ      | driving a read byte, MSB first
// READ_ACK  | sampling the master's ACK/NACK
// IGNORE    | not addressed or NACKed, waiting for START/STOP
module i2c_target_pcf
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = PCF8591_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] ctrl_reg,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       rd_req,
    output logic       busy
);

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    logic       sclS, sdaS, sclRise, sclFall, startDet, stopDet;
    i2cState_t  state;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;
    logic [7:0] txShift;
    logic [7:0] byteIdx;
    logic       ackPhase;
    logic       masterAck;
    logic [7:0] newByte;
    logic [7:0] loadByte;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_s    (sclS),
        .sda_s    (sdaS),
        .scl_rise (sclRise),
        .scl_fall (sclFall),
        .start    (startDet),
        .stop     (stopDet)
    );

    assign newByte  = {shiftReg[6:0], sdaS};
    assign loadByte = tx_valid ? tx_data : 8'hFF;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bitCnt    <= 3'd0;
            shiftReg  <= 8'h00;
            txShift   <= 8'h00;
            byteIdx   <= 8'h00;
            ackPhase  <= 1'b0;
            masterAck <= I2C_NACK;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            ctrl_reg  <= 8'h00;
            wr_data   <= 8'h00;
            wr_valid  <= 1'b0;
            rd_req    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            case (state)
                IDLE: ;
                ADDR: begin
                    if (sclRise) begin
                        shiftReg <= newByte;
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) state <= ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (sclFall) begin
                        if (!ackPhase) begin
                            if (shiftReg[7:1] == DEV_ADDR) begin
                                sda_oe   <= 1'b1;
                                busy     <= 1'b1;
                                ackPhase <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= IGNORE;
                            end
                        end else begin
                            sda_oe   <= 1'b0;
                            ackPhase <= 1'b0;
                            bitCnt   <= 3'd0;
                            byteIdx  <= 8'h00;
                            state    <= shiftReg[0] ? READ_LOAD : WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (sclRise) begin
                        shiftReg <= newByte;
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            state <= WRITE_ACK;
                            if (byteIdx == 8'h00) begin
                                ctrl_reg <= newByte;
                            end else begin
                                wr_data  <= newByte;
                                wr_valid <= 1'b1;
                            end
                            if (byteIdx != 8'hFF) byteIdx <= byteIdx + 8'd1;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (sclFall) begin
                        if (!ackPhase) begin
                            sda_oe   <= 1'b1;
                            ackPhase <= 1'b1;
                        end else begin
                            sda_oe   <= 1'b0;
                            ackPhase <= 1'b0;
                            bitCnt   <= 3'd0;
                            state    <= WRITE;
                        end
                    end
                end
                READ_LOAD: begin
                    // Only ever load and drive the first bit while SCL is low.
                    if (!sclS) begin
                        if (STRETCH_EN && !tx_valid) begin
                            scl_oe <= 1'b1;
                        end else begin
                            sda_oe  <= ~loadByte[7];
                            txShift <= {loadByte[6:0], 1'b0};
                            rd_req  <= tx_valid;
                            bitCnt  <= 3'd0;
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    scl_oe <= 1'b0;
                    if (sclRise) begin
                        bitCnt <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) state <= READ_ACK;
                    end else if (sclFall) begin
                        sda_oe  <= ~txShift[7];
                        txShift <= {txShift[6:0], 1'b0};
                    end
                end
                READ_ACK: begin
                    if (sclFall) begin
                        if (!ackPhase) begin
                            sda_oe   <= 1'b0;
                            ackPhase <= 1'b1;
                        end else begin
                            ackPhase <= 1'b0;
                            state    <= (masterAck == I2C_ACK) ? READ_LOAD : IGNORE;
                        end
                    end else if (sclRise && ackPhase) begin
                        masterAck <= sdaS;
                    end
                end
                IGNORE: ;
                default: state <= IDLE;
            endcase

            if (startDet) begin
                state    <= ADDR;
                bitCnt   <= 3'd0;
                ackPhase <= 1'b0;
                sda_oe   <= 1'b0;
                scl_oe   <= 1'b0;
            end
            if (stopDet) begin
                state    <= IDLE;
                ackPhase <= 1'b0;
                sda_oe   <= 1'b0;
                scl_oe   <= 1'b0;
                busy     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_pcf.sv
// Bench for i2c_target_pcf: a bit-banged open-drain master plus write/read scoreboards.
module tb_i2c_target_pcf;

    localparam int LOW  = 6;
    localparam int HIGH = 10;
    localparam int HOLD = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sclM = 1'b1;
    logic       sdaM = 1'b1;
    logic       sclLine, sdaLine;
    logic       sda_oe, scl_oe, wr_valid, rd_req, busy;
    logic       tx_valid = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] ctrl_reg, wr_data;

    assign sclLine = sclM & ~scl_oe;
    assign sdaLine = sdaM & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_pcf dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (sclLine),
        .sda_in   (sdaLine),
        .sda_oe   (sda_oe),
        .scl_oe   (scl_oe),
        .ctrl_reg (ctrl_reg),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .rd_req   (rd_req),
        .busy     (busy)
    );

    int errors = 0;
    int checks = 0;
    int wrCount = 0;
    int rdCount = 0;
    int oeCount = 0;
    logic [7:0] wrQ[$];
    logic [7:0] rdQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oeCount++;
        if (rd_req) rdCount++;
        if (wr_valid) begin
            wrCount++;
            if (wrQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got %0h with no byte expected", wr_data);
            end else begin
                check("wr_data", wr_data, wrQ.pop_front());
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clockBit(input logic drive, output logic sampled);
        int w;
        sdaM = drive;
        repeat (LOW) tick();
        sclM = 1'b1;
        w = 0;
        while (sclLine !== 1'b1 && w < 3000) begin
            tick();
            w++;
        end
        check("scl_released", sclLine, 1);
        repeat (HIGH / 2) tick();
        sampled = sdaLine;
        repeat (HIGH / 2) tick();
        sclM = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic startCond();
        sdaM = 1'b1;
        sclM = 1'b1;
        repeat (8) tick();
        sdaM = 1'b0;
        repeat (8) tick();
        sclM = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic repStart();
        sdaM = 1'b1;
        repeat (LOW) tick();
        sclM = 1'b1;
        repeat (8) tick();
        sdaM = 1'b0;
        repeat (8) tick();
        sclM = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic stopCond();
        sdaM = 1'b0;
        repeat (LOW) tick();
        sclM = 1'b1;
        repeat (8) tick();
        sdaM = 1'b1;
        repeat (8) tick();
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(b[i], s);
        clockBit(1'b1, s);
        ack = (s == 1'b0);
    endtask

    task automatic readByte(input logic ackBit, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(1'b1, b[i]);
        clockBit(ackBit, s);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       expAck;
        logic [7:0] expCtrl;
    } wrVec_t;

    wrVec_t vecs[4];

    initial begin
        logic       ack;
        logic [7:0] b;
        int         oe0, wr0, rd0, hold;

        vecs[0] = '{8'h90, 8'h04, 8'hA5, 8'h3C, 1'b1, 8'h04};
        vecs[1] = '{8'hA0, 8'h11, 8'h22, 8'h33, 1'b0, 8'h04};
        vecs[2] = '{8'h90, 8'hC3, 8'h00, 8'hFF, 1'b1, 8'hC3};
        vecs[3] = '{8'h92, 8'h55, 8'h66, 8'h77, 1'b0, 8'hC3};

        repeat (5) tick();
        check("rst_sda_oe", sda_oe, 0);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_ctrl_reg", ctrl_reg, 8'h00);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (5) tick();

        for (int v = 0; v < 4; v++) begin
            oe0 = oeCount;
            wr0 = wrCount;
            rd0 = rdCount;
            if (vecs[v].expAck) begin
                wrQ.push_back(vecs[v].d1);
                wrQ.push_back(vecs[v].d2);
            end
            startCond();
            writeByte(vecs[v].addr, ack);
            check("addr_ack", ack, vecs[v].expAck);
            writeByte(vecs[v].d0, ack);
            check("ctrl_ack", ack, vecs[v].expAck);
            writeByte(vecs[v].d1, ack);
            check("data1_ack", ack, vecs[v].expAck);
            writeByte(vecs[v].d2, ack);
            check("data2_ack", ack, vecs[v].expAck);
            check("busy_in_xfer", busy, vecs[v].expAck);
            stopCond();
            check("ctrl_reg", ctrl_reg, vecs[v].expCtrl);
            check("busy_after_stop", busy, 0);
            check("wr_strobes", wrCount - wr0, vecs[v].expAck ? 2 : 0);
            check("rd_strobes_on_write", rdCount - rd0, 0);
            if (!vecs[v].expAck) check("no_ack_drive", oeCount - oe0, 0);
        end

        // Two-byte read: ACK then NACK
        rd0 = rdCount;
        tx_data = 8'h7E;
        rdQ.push_back(8'h7E);
        startCond();
        writeByte(8'h91, ack);
        check("rd_addr_ack", ack, 1);
        tx_data = 8'h81;
        rdQ.push_back(8'h81);
        readByte(1'b0, b);
        check("rd_byte0", b, rdQ.pop_front());
        readByte(1'b1, b);
        check("rd_byte1", b, rdQ.pop_front());
        check("rd_req_count", rdCount - rd0, 2);
        check("sda_released_nack", sda_oe, 0);
        stopCond();
        check("rd_busy_after_stop", busy, 0);

        // Write control byte, repeated START, then read
        rd0 = rdCount;
        startCond();
        writeByte(8'h90, ack);
        check("rs_wr_addr_ack", ack, 1);
        writeByte(8'h01, ack);
        check("rs_ctrl_ack", ack, 1);
        repStart();
        tx_data = 8'h3C;
        writeByte(8'h91, ack);
        check("rs_rd_addr_ack", ack, 1);
        check("rs_ctrl_reg", ctrl_reg, 8'h01);
        check("rs_busy", busy, 1);
        readByte(1'b1, b);
        check("rs_rd_byte", b, 8'h3C);
        check("rs_rd_req_count", rdCount - rd0, 1);
        stopCond();

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
        rd0 = rdCount;
        tx_valid = 1'b0;
        startCond();
        writeByte(8'h91, ack);
        check("st_addr_ack", ack, 1);
        hold = 0;
        for (int i = 0; i < 50; i++) begin
            if (scl_oe) hold++;
            tick();
        end
        check("st_scl_held", hold, 50);
        check("st_no_rd_req", rdCount - rd0, 0);
        tx_data = 8'h55;
        tx_valid = 1'b1;
        repeat (3) tick();
        check("st_rd_req", rdCount - rd0, 1);
        check("st_scl_released", scl_oe, 0);
        readByte(1'b1, b);
        check("st_rd_byte", b, 8'h55);
        stopCond();
`else
        tx_valid = 1'b0;
        startCond();
        writeByte(8'h91, ack);
        check("ff_addr_ack", ack, 1);
        hold = 0;
        for (int i = 0; i < 20; i++) begin
            if (scl_oe) hold++;
            tick();
        end
        check("ff_no_stretch", hold, 0);
        readByte(1'b1, b);
        check("ff_rd_byte", b, 8'hFF);
        stopCond();
        tx_valid = 1'b1;
`endif

        // Reset in the middle of a read byte (target driving bit 3)
        tx_data = 8'hB6;
        startCond();
        writeByte(8'h91, ack);
        check("mr_addr_ack", ack, 1);
        for (int i = 7; i >= 4; i--) clockBit(1'b1, b[i]);
        check("mr_upper_nibble", b[7:4], 4'hB);
        check("mr_driving_bit3", sda_oe, 1);
        reset = 1'b0;
        tick();
        check("mr_sda_oe", sda_oe, 0);
        check("mr_scl_oe", scl_oe, 0);
        check("mr_busy", busy, 0);
        check("mr_ctrl_reg", ctrl_reg, 8'h00);
        check("mr_wr_data", wr_data, 8'h00);
        check("mr_strobes", {wr_valid, rd_req}, 2'b00);
        reset = 1'b1;
        tick();
        stopCond();
        startCond();
        writeByte(8'h90, ack);
        check("post_rst_addr_ack", ack, 1);
        writeByte(8'h77, ack);
        check("post_rst_ctrl_ack", ack, 1);
        stopCond();
        check("post_rst_ctrl_reg", ctrl_reg, 8'h77);
        check("wr_queue_drained", wrQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
